// File: rtl/apuf_pkg.sv
// Shared types and defaults for the arbiter PUF response reader.
package apuf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_SETTLE,
      ST_SAMPLE,
      ST_GAP,
      ST_DONE
   } apuf_state_e;

   localparam int unsigned DEF_CHAL_W = 64;
   localparam int unsigned DEF_N_EVAL = 7;
   localparam int unsigned DEF_SETTLE = 4;
   localparam int unsigned DEF_GAP    = 2;

   // Majority is reached when the ones-count strictly exceeds this value.
   function automatic int unsigned maj_threshold(input int unsigned n_eval);
      return n_eval / 2;
   endfunction

endpackage

// File: rtl/apuf_phase_timer.sv
// Loadable down-counter timing the settle and discharge windows.
module apuf_phase_timer #(
   parameter int unsigned TW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   output logic          done_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Loaded with window-1, so done marks the last cycle of the window.
   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/apuf_response_reader.sv
// Drives a challenge onto the mux chain, launches N_EVAL evaluations and majority-votes the arbiter.
module apuf_response_reader
   import apuf_pkg::*;
#(
   parameter int unsigned CHAL_W = DEF_CHAL_W,
   parameter int unsigned N_EVAL = DEF_N_EVAL,
   parameter int unsigned SETTLE = DEF_SETTLE,
   parameter int unsigned GAP    = DEF_GAP,
   localparam int unsigned CW    = $clog2(N_EVAL + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chal_valid,
   output logic              chal_ready,
   input  logic [CHAL_W-1:0] chal,
   output logic [CHAL_W-1:0] chain_select,
   output logic              launch,
   input  logic              arb_in,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp,
   output logic              resp_stable,
   output logic [CW-1:0]     ones_count
);

   localparam int unsigned TMAX = (SETTLE > GAP) ? SETTLE : GAP;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   apuf_state_e       state_q, state_d;
   logic [CHAL_W-1:0] sel_q, sel_d;
   logic              launch_q, launch_d;
   logic              rvalid_q, rvalid_d;
   logic [CW-1:0]     ones_q, ones_d;
   logic [CW-1:0]     eval_q, eval_d;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_done;
   logic              accept;
   logic              handshake;

   apuf_phase_timer #(
      .TW (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   assign accept    = (state_q == ST_IDLE) && chal_valid;
   assign handshake = rvalid_q && resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         launch_q <= 1'b0;
         rvalid_q <= 1'b0;
         ones_q   <= '0;
         eval_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         launch_q <= launch_d;
         rvalid_q <= rvalid_d;
         ones_q   <= ones_d;
         eval_q   <= eval_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (chal_valid) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_SETTLE;
         ST_SETTLE: if (tmr_done) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = ST_GAP;
         ST_GAP: begin
            if (tmr_done) begin
               state_d = (eval_q < CW'(N_EVAL)) ? ST_LAUNCH : ST_DONE;
            end
         end
         ST_DONE:   if (handshake) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // launch and resp_valid are registered from the current state, hence one cycle behind it.
   always_comb begin
      sel_d    = sel_q;
      ones_d   = ones_q;
      eval_d   = eval_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      launch_d = (state_q == ST_LAUNCH) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
      rvalid_d = (state_q == ST_DONE) && !handshake;
      if (accept) begin
         sel_d  = chal;
         ones_d = '0;
         eval_d = '0;
      end
      if (state_q == ST_LAUNCH) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(SETTLE - 1);
      end
      if (state_q == ST_SAMPLE) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(GAP - 1);
         ones_d   = ones_q + CW'(arb_in);
         eval_d   = eval_q + CW'(1);
      end
   end

   assign chal_ready   = (state_q == ST_IDLE);
   assign chain_select = sel_q;
   assign launch       = launch_q;
   assign resp_valid   = rvalid_q;
   assign ones_count   = ones_q;
   assign resp         = rvalid_q && (ones_q > CW'(maj_threshold(N_EVAL)));
   assign resp_stable  = rvalid_q && ((ones_q == '0) || (ones_q == CW'(N_EVAL)));

endmodule

// File: tb/tb_apuf_response_reader.sv
// Directed bench for the PUF response reader: default build plus an N_EVAL=1/SETTLE=1/GAP=1 build.
module tb_apuf_response_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        chal_valid, chal_ready;
   logic [63:0] chal, chain_select;
   logic        launch, arb_in;
   logic        resp_valid, resp_ready, resp, resp_stable;
   logic [2:0]  ones_count;

   logic        b_chal_valid, b_chal_ready;
   logic [7:0]  b_chal, b_chain_select;
   logic        b_launch, b_arb_in;
   logic        b_resp_valid, b_resp_ready, b_resp, b_resp_stable;
   logic [0:0]  b_ones_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   apuf_response_reader dut (
      .clk          (clk),
      .rst          (rst),
      .chal_valid   (chal_valid),
      .chal_ready   (chal_ready),
      .chal         (chal),
      .chain_select (chain_select),
      .launch       (launch),
      .arb_in       (arb_in),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp         (resp),
      .resp_stable  (resp_stable),
      .ones_count   (ones_count)
   );

   apuf_response_reader #(
      .CHAL_W (8),
      .N_EVAL (1),
      .SETTLE (1),
      .GAP    (1)
   ) dut_min (
      .clk          (clk),
      .rst          (rst),
      .chal_valid   (b_chal_valid),
      .chal_ready   (b_chal_ready),
      .chal         (b_chal),
      .chain_select (b_chain_select),
      .launch       (b_launch),
      .arb_in       (b_arb_in),
      .resp_valid   (b_resp_valid),
      .resp_ready   (b_resp_ready),
      .resp         (b_resp),
      .resp_stable  (b_resp_stable),
      .ones_count   (b_ones_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: arb tied 1; mode 1: toggles per sample starting at 1; mode 2: starting at 0.
   task automatic run_eval(input logic [63:0] c, input int mode, input int exp_ones,
                           input logic exp_resp, input logic exp_stable,
                           input int hold, input logic pulse_mid);
      int   pulses, badlen, run, lat, bad;
      logic prev, odd;
      pulses = 0; badlen = 0; run = 0; lat = 0; bad = 0; prev = 1'b0;
      check("chal_ready_idle", 64'(chal_ready), 64'd1);
      chal = c;
      chal_valid = 1'b1;
      tick();
      chal_valid = 1'b0;
      check("chain_select_load", chain_select, c);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         // Sample k is taken at edge 8k+6, so cyc/8 indexes the evaluation.
         odd = ((cyc / 8) % 2) == 1;
         case (mode)
            1:       arb_in = !odd;
            2:       arb_in = odd;
            default: arb_in = 1'b1;
         endcase
         if (pulse_mid && cyc == 21) begin
            chal_valid = 1'b1;
            chal = ~c;
         end
         if (pulse_mid && cyc == 22) begin
            chal_valid = 1'b0;
            chal = c;
         end
         tick();
         if (launch && !prev) begin
            pulses++;
            run = 0;
         end
         if (launch) run++;
         if (!launch && prev && run != 6) badlen++;
         prev = launch;
         if (resp_valid) begin
            lat = cyc;
            break;
         end
      end
      chal_valid = 1'b0;
      check("resp_valid_latency", 64'(lat), 64'd57);
      check("launch_pulse_count", 64'(pulses), 64'd7);
      check("launch_pulse_len_bad", 64'(badlen), 64'd0);
      check("chain_select_held", chain_select, c);
      check("ones_count", 64'(ones_count), 64'(exp_ones));
      check("resp", 64'(resp), 64'(exp_resp));
      check("resp_stable", 64'(resp_stable), 64'(exp_stable));
      for (int i = 0; i < hold; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp !== exp_resp || resp_stable !== exp_stable ||
             ones_count !== 3'(exp_ones) || chal_ready !== 1'b0 || chain_select !== c)
            bad++;
      end
      check("hold_unstable_cycles", 64'(bad), 64'd0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("resp_valid_after_hs", 64'(resp_valid), 64'd0);
      check("chal_ready_after_hs", 64'(chal_ready), 64'd1);
      check("chain_select_kept", chain_select, c);
   endtask

   initial begin
      logic [7:0] bv [3];
      int         lat;
      bv = '{8'h3C, 8'hC3, 8'h5A};
      rst = 1'b1;
      chal_valid = 1'b0; chal = '0; arb_in = 1'b0; resp_ready = 1'b0;
      b_chal_valid = 1'b0; b_chal = '0; b_arb_in = 1'b0; b_resp_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      check("rst_chal_ready", 64'(chal_ready), 64'd1);
      check("rst_chain_select", chain_select, 64'd0);
      check("rst_launch", 64'(launch), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp", 64'(resp), 64'd0);
      check("rst_resp_stable", 64'(resp_stable), 64'd0);
      check("rst_ones_count", 64'(ones_count), 64'd0);

      run_eval(64'hA5A5_0000_FFFF_1234, 0, 7, 1'b1, 1'b1, 0, 1'b0);
      run_eval(64'h0123_4567_89AB_CDEF, 1, 4, 1'b1, 1'b0, 10, 1'b1);
      run_eval(64'hDEAD_BEEF_0000_0001, 2, 3, 1'b0, 1'b0, 0, 1'b0);

      // Reset while launch is high in the third settle window.
      chal = 64'h1111_2222_3333_4444;
      chal_valid = 1'b1;
      tick();
      chal_valid = 1'b0;
      arb_in = 1'b1;
      repeat (18) tick();
      check("launch_in_settle3", 64'(launch), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_launch", 64'(launch), 64'd0);
      check("rst_mid_chal_ready", 64'(chal_ready), 64'd1);
      check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
      run_eval(64'h7777_0000_7777_0000, 0, 7, 1'b1, 1'b1, 0, 1'b0);

      // Minimal build: back-to-back challenges, each accepted the cycle after the handshake.
      for (int k = 0; k < 3; k++) begin
         b_chal = bv[k];
         b_arb_in = (k % 2) == 0;
         b_chal_valid = 1'b1;
         tick();
         b_chal_valid = 1'b0;
         check("min_chain_select", 64'(b_chain_select), 64'(bv[k]));
         lat = 0;
         for (int cyc = 1; cyc <= 50; cyc++) begin
            tick();
            if (b_resp_valid) begin
               lat = cyc;
               break;
            end
         end
         check("min_latency", 64'(lat), 64'd5);
         check("min_resp", 64'(b_resp), 64'((k % 2) == 0));
         check("min_resp_stable", 64'(b_resp_stable), 64'd1);
         check("min_ones_count", 64'(b_ones_count), 64'((k % 2) == 0));
         b_resp_ready = 1'b1;
         tick();
         b_resp_ready = 1'b0;
         check("min_resp_valid_after_hs", 64'(b_resp_valid), 64'd0);
         check("min_chal_ready_after_hs", 64'(b_chal_ready), 64'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
